wb_fifo_target: RTL and testbench

Wishbone B4 classic target that sits inside `user_project_wrapper`, directly downstream of the Wishbone initiator port (`wbs_*`). It receives pushes from the initiator into a small synchronous FIFO and delivers them on a valid/ready stream to user logic. Status and control registers are readable and writable over the same bus. It is the first user-side consumer of host-driven Wishbone traffic in bring-up tests.

---
 rtl/wb_fifo_target_pkg.sv | 17 +
 rtl/wb_fifo_target_fifo_sync.sv | 69 ++++++
 rtl/wb_fifo_target.sv | 101 ++++++++++
 tb/tb_wb_fifo_target.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_fifo_target_pkg.sv
// Shared register map and bit positions for the Wishbone FIFO target.
// Offsets are word indices taken from adr_i[3:2].
package wb_fifo_target_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;

  localparam int ST_EMPTY   = 0;
  localparam int ST_FULL    = 1;
  localparam int ST_OVF     = 2;
  localparam int ST_CNT_LSB = 8;

  localparam int CTRL_FLUSH   = 0;
  localparam int CTRL_CLR_OVF = 1;

endpackage

// File: rtl/wb_fifo_target_fifo_sync.sv
// Synchronous FIFO with a registered output stage and flush.
// The stream head trails storage by one cycle: no fall-through.
module fifo_sync #(
  parameter int DW    = 32,
  parameter int DEPTH = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic [DW-1:0]            push_data,
  input  logic                     pop,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [DW-1:0]            head,
  output logic                     out_valid,
  output logic [DW-1:0]            out_data
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW-1:0] rd_idx;
  logic [CW-1:0] cnt_nxt;
  logic          wr;
  logic          rd;

  assign full  = count == CW'(DEPTH);
  assign empty = count == '0;
  assign head  = mem[rptr];
  assign wr    = push & ~full & ~flush & ~reset;
  assign rd    = pop & out_valid;

  always_comb begin
    cnt_nxt = count + CW'(wr) - CW'(rd);
    rd_idx  = rptr + AW'(rd);
  end

  always_ff @(posedge clock) begin
    if (wr) mem[wptr] <= push_data;
  end

  // Visibility uses the pre-edge count so a fresh push shows a cycle later.
  always_ff @(posedge clock) begin
    if (reset) begin
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (flush) begin
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      out_valid <= 1'b0;
    end else begin
      if (wr) wptr <= wptr + 1'b1;
      if (rd) rptr <= rptr + 1'b1;
      count     <= cnt_nxt;
      out_valid <= (count - CW'(rd)) != '0;
      out_data  <= mem[rd_idx];
    end
  end

endmodule

// File: rtl/wb_fifo_target.sv
// Wishbone B4 classic target pushing bus writes into a stream FIFO.
// Holds bus decode, single-cycle ack, readback and the overflow flag.
module wb_fifo_target
  import wb_fifo_target_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    DEPTH      = 8,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h3000_0000
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      stb_i,
  input  logic                      cyc_i,
  input  logic                      we_i,
  input  logic [DATA_WIDTH/8-1:0]   sel_i,
  input  logic [ADDR_WIDTH-1:0]     adr_i,
  input  logic [DATA_WIDTH-1:0]     dat_i,
  output logic                      ack_o,
  output logic [DATA_WIDTH-1:0]     dat_o,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_WIDTH-1:0]     out_data
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic                  hit;
  logic [1:0]            reg_sel;
  logic                  push;
  logic                  ctrl_wr;
  logic                  flush;
  logic                  clr_ovf;
  logic                  pop;
  logic                  full;
  logic                  empty;
  logic                  overflow;
  logic [CW-1:0]         count;
  logic [DATA_WIDTH-1:0] head;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  unused_ok;

  assign hit = cyc_i & stb_i & ~ack_o &
               (adr_i[ADDR_WIDTH-1:4] == BASE_ADDR[ADDR_WIDTH-1:4]);
  assign reg_sel = adr_i[3:2];
  assign push    = hit & we_i & (reg_sel == REG_DATA);
  assign ctrl_wr = hit & we_i & (reg_sel == REG_CTRL) & sel_i[0];
  assign flush   = ctrl_wr & dat_i[CTRL_FLUSH];
  assign clr_ovf = ctrl_wr & dat_i[CTRL_CLR_OVF];
  assign pop     = out_valid & out_ready;

  assign unused_ok = ^{sel_i[DATA_WIDTH/8-1:1], adr_i[1:0]};

  always_comb begin
    rdata = '0;
    unique case (1'b1)
      reg_sel == REG_DATA: begin
        if (!empty) rdata = head;
      end
      reg_sel == REG_STATUS: begin
        rdata[ST_EMPTY]          = empty;
        rdata[ST_FULL]           = full;
        rdata[ST_OVF]            = overflow;
        rdata[ST_CNT_LSB +: CW]  = count;
      end
      default: rdata = '0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ack_o    <= 1'b0;
      dat_o    <= '0;
      overflow <= 1'b0;
    end else begin
      ack_o <= hit;
      dat_o <= (hit & ~we_i) ? rdata : '0;
      if (clr_ovf)          overflow <= 1'b0;
      else if (push & full) overflow <= 1'b1;
    end
  end

  fifo_sync #(
    .DW    (DATA_WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .flush     (flush),
    .push      (push),
    .push_data (dat_i),
    .pop       (pop),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .head      (head),
    .out_valid (out_valid),
    .out_data  (out_data)
  );

endmodule

// File: tb/tb_wb_fifo_target.sv
// Directed bench for wb_fifo_target with a queue-based reference model.
// The model is checked every cycle; literal checks pin key results.
module tb_wb_fifo_target;

  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam int          DEP  = 8;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        stb_i = 1'b0;
  logic        cyc_i = 1'b0;
  logic        we_i  = 1'b0;
  logic [3:0]  sel_i = 4'h0;
  logic [31:0] adr_i = '0;
  logic [31:0] dat_i = '0;
  logic        ack_o;
  logic [31:0] dat_o;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;

  int pass_cnt = 0;
  int total    = 0;
  bit chk_en   = 1'b0;

  logic [31:0] q[$];
  logic [31:0] got[$];
  bit          m_ovf;
  bit          e_ack;
  logic [31:0] e_dat;
  bit          e_valid;
  logic [31:0] e_data;

  wb_fifo_target dut (
    .clock     (clock),
    .reset     (reset),
    .stb_i     (stb_i),
    .cyc_i     (cyc_i),
    .we_i      (we_i),
    .sel_i     (sel_i),
    .adr_i     (adr_i),
    .dat_i     (dat_i),
    .ack_o     (ack_o),
    .dat_o     (dat_o),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  // Reference: FIFO contents as a queue; a word is visible on the
  // stream only if it was stored before the edge and not popped there.
  always @(posedge clock) begin
    automatic bit          hit;
    automatic int          n;
    automatic bit          pp;
    automatic bit          fl;
    automatic logic [31:0] rv;
    hit = cyc_i && stb_i && !e_ack && (adr_i[31:4] == BASE[31:4]);
    n   = q.size();
    pp  = e_valid && out_ready;
    fl  = 1'b0;
    rv  = '0;
    if (reset) begin
      q.delete();
      m_ovf   = 1'b0;
      e_ack   = 1'b0;
      e_dat   = '0;
      e_valid = 1'b0;
      e_data  = '0;
    end else begin
      case (adr_i[3:2])
        2'd0: rv = (n > 0) ? q[0] : 32'h0;
        2'd1: rv = {16'h0, 8'(n), 5'h0, m_ovf, n == DEP, n == 0};
        default: rv = 32'h0;
      endcase
      e_ack = hit;
      e_dat = (hit && !we_i) ? rv : 32'h0;
      if (hit && we_i && adr_i[3:2] == 2'd2 && sel_i[0]) begin
        if (dat_i[1]) m_ovf = 1'b0;
        if (dat_i[0]) begin
          q.delete();
          fl = 1'b1;
        end
      end
      if (!fl) begin
        if (pp) void'(q.pop_front());
        if (hit && we_i && adr_i[3:2] == 2'd0) begin
          if (n == DEP) m_ovf = 1'b1;
          else q.push_back(dat_i);
        end
      end
      e_valid = !fl && (n - int'(pp)) > 0;
      if (e_valid) e_data = q[0];
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      chk("ack_o", {31'h0, ack_o}, {31'h0, e_ack});
      if (e_ack) chk("dat_o", dat_o, e_dat);
      chk("out_valid", {31'h0, out_valid}, {31'h0, e_valid});
      if (e_valid) chk("out_data", out_data, e_data);
      if (out_valid && out_ready) got.push_back(out_data);
    end
  end

  // Called at posedge+1; returns at posedge+1 with the bus idle.
  task automatic wb(input bit w, input logic [31:0] a,
                    input logic [31:0] d, input logic [3:0] s,
                    output logic [31:0] rd, output int lat);
    cyc_i = 1'b1; stb_i = 1'b1; we_i = w;
    adr_i = a; dat_i = d; sel_i = s;
    rd = '0; lat = -1;
    for (int i = 1; i <= 17; i++) begin
      @(negedge clock);
      if (ack_o) begin
        lat = i - 1;
        rd  = dat_o;
        break;
      end
    end
    @(posedge clock); #1;
    cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] r;
    int          l;
    wb(1'b1, a, d, 4'hF, r, l);
    chk("wr_ack_lat", l, 1);
  endtask

  task automatic rd_reg(input logic [31:0] a, output logic [31:0] r);
    int l;
    wb(1'b0, a, 32'h0, 4'hF, r, l);
    chk("rd_ack_lat", l, 1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  initial begin
    logic [31:0] r;
    int          l;
    @(posedge clock); #1;
    chk_en = 1'b1;
    @(negedge clock);
    chk("rst_ack", {31'h0, ack_o}, 32'h0);
    chk("rst_dat", dat_o, 32'h0);
    chk("rst_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_odata", out_data, 32'h0);
    @(posedge clock); #1;
    reset = 1'b0;
    idle(1);

    rd_reg(BASE + 32'h4, r);
    chk("status_reset", r, 32'h0000_0001);

    for (int i = 1; i <= 3; i++) wr(BASE, 32'hA5A5_0000 + i);
    rd_reg(BASE + 32'h4, r);
    chk("status_3", r, 32'h0000_0300);
    rd_reg(BASE, r);
    chk("peek_head", r, 32'hA5A5_0001);
    got.delete();
    out_ready = 1'b1;
    idle(5);
    out_ready = 1'b0;
    chk("stream3_n", got.size(), 3);
    for (int i = 0; i < got.size() && i < 3; i++)
      chk("stream3_w", got[i], 32'hA5A5_0001 + i);

    for (int i = 0; i < 9; i++) wr(BASE, 32'h100 + i);
    rd_reg(BASE + 32'h4, r);
    chk("status_ovf", r, 32'h0000_0806);
    got.delete();
    out_ready = 1'b1;
    idle(12);
    out_ready = 1'b0;
    chk("ovf_n", got.size(), 8);
    for (int i = 0; i < got.size() && i < 8; i++)
      chk("ovf_w", got[i], 32'h100 + i);

    wr(BASE + 32'h8, 32'h2);
    for (int i = 0; i < 8; i++) wr(BASE, 32'h200 + i);
    got.delete();
    out_ready = 1'b1;
    wr(BASE, 32'h2FF);
    idle(12);
    out_ready = 1'b0;
    chk("fullpop_n", got.size(), 8);
    for (int i = 0; i < got.size() && i < 8; i++)
      chk("fullpop_w", got[i], 32'h200 + i);
    rd_reg(BASE + 32'h4, r);
    chk("status_fp", r, 32'h0000_0005);

    for (int i = 0; i < 4; i++) wr(BASE, 32'h300 + i);
    out_ready = 1'b1;
    wr(BASE + 32'h8, 32'h3);
    chk("flush_valid", {31'h0, out_valid}, 32'h0);
    out_ready = 1'b0;
    rd_reg(BASE + 32'h4, r);
    chk("status_flush", r, 32'h0000_0001);

    wb(1'b0, BASE + 32'h10, 32'h0, 4'hF, r, l);
    chk("miss_rd", l, -1);
    wb(1'b1, BASE + 32'h10, 32'h55, 4'hF, r, l);
    chk("miss_wr", l, -1);
    rd_reg(BASE + 32'hC, r);
    chk("reg_c", r, 32'h0);

    wr(BASE, 32'h400);
    wr(BASE, 32'h401);
    cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b1;
    adr_i = BASE; dat_i = 32'h4FF; sel_i = 4'hF;
    reset = 1'b1;
    @(negedge clock);
    chk("rst_mid_ack", {31'h0, ack_o}, 32'h0);
    @(posedge clock); #1;
    reset = 1'b0;
    cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
    @(negedge clock);
    chk("rst_mid_ack2", {31'h0, ack_o}, 32'h0);
    @(posedge clock); #1;
    rd_reg(BASE + 32'h4, r);
    chk("status_rst", r, 32'h0000_0001);

    idle(2);
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
